// File: rtl/spm_pkg.sv
//------------------------------------------------------------------------------
// spm_pkg : opcodes, FSM state encoding and instruction field helpers for spm_core
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spm_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;
  localparam logic [3:0] OP_IRD = 4'd9;
  localparam logic [3:0] OP_IWR = 4'd10;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_DEC   = 4'd2;
  localparam logic [3:0] S_OPND  = 4'd3;
  localparam logic [3:0] S_XFER  = 4'd4;
  localparam logic [3:0] S_HALT  = 4'd5;

  // Helpers take the instruction zero-extended to 64 bits so one definition
  // serves every WORD_W; callers size-cast the result to their field width.
  function automatic logic [3:0] f_opcode(input logic [63:0] ir, input int word_w);
    return ir[word_w-1 -: 4];
  endfunction

  function automatic logic [63:0] f_src(input logic [63:0] ir, input int reg_aw);
    return (ir >> reg_aw) & ((64'd1 << reg_aw) - 64'd1);
  endfunction

  function automatic logic [63:0] f_dst(input logic [63:0] ir, input int reg_aw);
    return ir & ((64'd1 << reg_aw) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spm_regfile.sv
//------------------------------------------------------------------------------
// spm_regfile : REG_N x WORD_W register file, two async read ports, one write port
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spm_regfile #(
  parameter int WORD_W = 8,
  parameter int REG_N  = 4,
  parameter int REG_AW = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_a_addr_i,
  output logic [WORD_W-1:0] rd_a_data_o,
  input  logic [REG_AW-1:0] rd_b_addr_i,
  output logic [WORD_W-1:0] rd_b_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i
);

  logic [WORD_W-1:0] regs_q [REG_N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_a_data_o = regs_q[rd_a_addr_i];
  assign rd_b_data_o = regs_q[rd_b_addr_i];

endmodule

`default_nettype wire

// File: rtl/spm_core.sv
//------------------------------------------------------------------------------
// spm_core : multi-cycle stored-program RISC core with handshaked memory/IO bus
// Optional bus-ack timeout enabled by defining SPM_BUS_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spm_core
  import spm_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int REG_N   = 4,
  parameter int REG_AW  = $clog2(REG_N),
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bus_req,
  output logic              bus_we,
  output logic              bus_io,
  output logic [WORD_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              halted,
  output logic              bus_err,
  output logic [WORD_W-1:0] pc_dbg
);

  logic [3:0]        state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              z_q, z_d;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] src, dst;
  logic [WORD_W-1:0] src_val, dst_val, alu_res;
  logic              rf_we;
  logic [WORD_W-1:0] rf_wdata;
  logic              xfer_ack, is_io, is_wr, in_xfer, timeout;

  assign opcode = f_opcode(64'(ir_q), WORD_W);
  assign src    = REG_AW'(f_src(64'(ir_q), REG_AW));
  assign dst    = REG_AW'(f_dst(64'(ir_q), REG_AW));

  spm_regfile #(
    .WORD_W (WORD_W),
    .REG_N  (REG_N),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .rd_a_addr_i (src),
    .rd_a_data_o (src_val),
    .rd_b_addr_i (dst),
    .rd_b_data_o (dst_val),
    .we_i        (rf_we),
    .waddr_i     (dst),
    .wdata_i     (rf_wdata)
  );

  always_comb begin
    case (opcode)
      OP_ADD:  alu_res = src_val + dst_val;
      OP_SUB:  alu_res = dst_val - src_val;
      OP_AND:  alu_res = src_val & dst_val;
      default: alu_res = ~src_val;
    endcase
  end

  // Bus outputs decode purely from registered state, so they hold through waits.
  assign is_io     = (opcode == OP_IRD) || (opcode == OP_IWR);
  assign is_wr     = (opcode == OP_WR)  || (opcode == OP_IWR);
  assign in_xfer   = (state_q == S_XFER);
  assign bus_req   = (state_q == S_FETCH) || (state_q == S_OPND) || in_xfer;
  assign bus_addr  = in_xfer ? addr_q : (bus_req ? pc_q : '0);
  assign bus_we    = in_xfer & is_wr;
  assign bus_io    = in_xfer & is_io;
  assign bus_wdata = (in_xfer & is_wr) ? src_val : '0;
  assign xfer_ack  = bus_req & bus_ack;
  assign halted    = (state_q == S_HALT);
  assign pc_dbg    = pc_q;

`ifdef SPM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  assign timeout = bus_req & ~bus_ack & (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign bus_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (!bus_req || bus_ack || timeout) begin
      wait_cnt_q <= '0;
      if (timeout) err_q <= 1'b1;
    end else begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    z_d      = z_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (xfer_ack) begin
          ir_d    = bus_rdata;
          pc_d    = pc_q + WORD_W'(1);
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
            rf_we   = 1'b1;
            z_d     = (alu_res == '0);
            state_d = S_FETCH;
          end
          OP_RD, OP_WR, OP_IRD, OP_IWR, OP_BR: state_d = S_OPND;
          OP_BRZ: begin
            if (z_q) begin
              state_d = S_OPND;
            end else begin
              pc_d    = pc_q + WORD_W'(1);
              state_d = S_FETCH;
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_OPND: begin
        if (xfer_ack) begin
          if ((opcode == OP_BR) || (opcode == OP_BRZ)) begin
            pc_d    = bus_rdata;
            state_d = S_FETCH;
          end else begin
            addr_d  = bus_rdata;
            pc_d    = pc_q + WORD_W'(1);
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (xfer_ack) begin
          if (!is_wr) begin
            rf_we    = 1'b1;
            rf_wdata = bus_rdata;
          end
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (timeout) state_d = S_HALT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      z_q     <= z_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spm_core.sv
//------------------------------------------------------------------------------
// tb_spm_core : scoreboard bench for spm_core; an ISA-level model predicts
// every bus transaction, a bus-slave monitor pops and compares them.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spm_core;

  logic       clk, rst;
  logic       bus_req, bus_we, bus_io, bus_ack, halted, bus_err;
  logic [7:0] bus_addr, bus_wdata, bus_rdata, pc_dbg;

  spm_core dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_io    (bus_io),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .halted    (halted),
    .bus_err   (bus_err),
    .pc_dbg    (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic       io;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] smem  [256];
  logic [7:0] mmem  [256];
  logic [7:0] io_rd [256];
  int         passed = 0;
  int         total  = 0;
  int         wait_mode;
  bit         model_halted;
  int         exp_cycles, exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic void push(input int a, input bit we, input bit io, input int wd);
    exp_q.push_back('{addr: 8'(a), we: we, io: io, wdata: 8'(wd)});
  endfunction

  // ISA-level reference: executes instructions on its own memory copy.
  task automatic run_model(input int max_instr, input int waits);
    int r[4];
    bit z;
    int pc, ir, op, s, d, opnd, res, w;
    w = (waits < 0) ? 0 : waits;
    for (int i = 0; i < 4; i++) r[i] = 0;
    z = 0; pc = 0; exp_cycles = 1; model_halted = 0;
    for (int n = 0; n < max_instr && !model_halted; n++) begin
      ir = int'(mmem[pc]);
      push(pc, 0, 0, 0);
      pc = (pc + 1) % 256;
      op = ir / 16; s = (ir / 4) % 4; d = ir % 4;
      case (op)
        0: exp_cycles += 2 + w;
        1, 2, 3, 4: begin
          case (op)
            1:       res = (r[s] + r[d]) % 256;
            2:       res = (r[d] - r[s] + 256) % 256;
            3:       res = r[s] & r[d];
            default: res = 255 - r[s];
          endcase
          r[d] = res;
          z = (res == 0);
          exp_cycles += 2 + w;
        end
        5, 6, 9, 10: begin
          opnd = int'(mmem[pc]);
          push(pc, 0, 0, 0);
          pc = (pc + 1) % 256;
          if (op == 5 || op == 9) begin
            push(opnd, 0, op == 9, 0);
            r[d] = (op == 9) ? int'(io_rd[opnd]) : int'(mmem[opnd]);
          end else begin
            push(opnd, 1, op == 10, r[s]);
            if (op == 6) mmem[opnd] = 8'(r[s]);
          end
          exp_cycles += 4 + 3 * w;
        end
        7: begin
          push(pc, 0, 0, 0);
          pc = int'(mmem[pc]);
          exp_cycles += 3 + 2 * w;
        end
        8: begin
          if (z) begin
            push(pc, 0, 0, 0);
            pc = int'(mmem[pc]);
            exp_cycles += 3 + 2 * w;
          end else begin
            pc = (pc + 1) % 256;
            exp_cycles += 2 + w;
          end
        end
        default: begin
          model_halted = 1;
          exp_cycles += 2 + w;
        end
      endcase
    end
    exp_pc = pc;
  endtask

  // Bus slave and scoreboard monitor.
  bit         in_txn = 0;
  int         wleft;
  logic [7:0] cap_addr, cap_wd;
  logic       cap_we, cap_io;
  txn_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      bus_ack = 1'b0;
      in_txn  = 0;
    end else begin
      bus_ack = 1'b0;
      if (bus_req) begin
        if (!in_txn) begin
          in_txn = 1;
          cap_addr = bus_addr; cap_we = bus_we; cap_io = bus_io; cap_wd = bus_wdata;
          if (wait_mode >= 0)       wleft = wait_mode;
          else if (wait_mode == -1) wleft = int'($urandom_range(0, 3));
          else                      wleft = 1 << 30;
        end else begin
          chk("stable_addr", 32'(bus_addr), 32'(cap_addr));
          chk("stable_ctl", 32'({bus_we, bus_io}), 32'({cap_we, cap_io}));
          if (cap_we) chk("stable_wdata", 32'(bus_wdata), 32'(cap_wd));
        end
        if (wleft == 0) begin
          if (exp_q.size() == 0) begin
            if (model_halted) chk("txn_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("txn_addr", 32'(bus_addr), 32'(e.addr));
            chk("txn_we", 32'(bus_we), 32'(e.we));
            chk("txn_io", 32'(bus_io), 32'(e.io));
            if (e.we) chk("txn_wdata", 32'(bus_wdata), 32'(e.wdata));
          end
          if (!bus_we) bus_rdata = bus_io ? io_rd[bus_addr] : smem[bus_addr];
          else if (!bus_io) smem[bus_addr] = bus_wdata;
          bus_ack = 1'b1;
          in_txn  = 0;
        end else begin
          wleft--;
        end
      end else if (in_txn) begin
        if (!halted) chk("req_held", 32'(bus_req), 32'd1);
        in_txn = 0;
      end
    end
  end

  task automatic fill_io();
    for (int i = 0; i < 256; i++) io_rd[i] = 8'($urandom);
  endtask

  task automatic load_loop();
    for (int i = 0; i < 256; i++) smem[i] = 8'hF0;
    smem[0] = 8'h51; smem[1] = 8'h20;   // RD R1,[0x20]
    smem[2] = 8'h50; smem[3] = 8'h21;   // RD R0,[0x21]
    smem[4] = 8'h21;                    // SUB R1,R0
    smem[5] = 8'h80; smem[6] = 8'h0A;   // BRZ 0x0A
    smem[7] = 8'h70; smem[8] = 8'h04;   // BR 0x04
    smem[10] = 8'h64; smem[11] = 8'h30; // WR R1,[0x30]
    smem[12] = 8'hF0;
    smem[8'h20] = 8'd6; smem[8'h21] = 8'd1;
    fill_io();
    mmem = smem;
  endtask

  task automatic load_io();
    for (int i = 0; i < 256; i++) smem[i] = 8'hF0;
    smem[0] = 8'h52; smem[1] = 8'h22;   // RD R2,[0x22]
    smem[2] = 8'hA8; smem[3] = 8'h05;   // IWR R2,io[0x05]
    smem[4] = 8'h30;                    // AND R0,R0 -> Z=1
    smem[5] = 8'h93; smem[6] = 8'h10;   // IRD R3,io[0x10]
    smem[7] = 8'h80; smem[8] = 8'h0B;   // BRZ 0x0B
    smem[11] = 8'h6C; smem[12] = 8'h31; // WR R3,[0x31]
    smem[8'h22] = 8'hA5;
    fill_io();
    io_rd[8'h10] = 8'h3C;
    mmem = smem;
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++)
      smem[i] = 8'(($urandom_range(0, 11) << 4) | $urandom_range(0, 15));
    fill_io();
    mmem = smem;
  endtask

  task automatic run_prog(input int waits, input int max_instr);
    int cyc;
    bit done;
    exp_q.delete();
    run_model(max_instr, waits);
    wait_mode = waits;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0; done = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      done = model_halted ? halted : (exp_q.size() == 0);
    end
    chk("run_done", 32'(done), 32'd1);
    if (model_halted) begin
      chk("final_pc", 32'(pc_dbg), 32'(exp_pc));
      chk("txn_left", 32'(exp_q.size()), 32'd0);
      chk("halt_no_req", 32'(bus_req), 32'd0);
      if (waits >= 0) chk("cycles", 32'(cyc), 32'(exp_cycles));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00; wait_mode = 0; model_halted = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc_dbg), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_addr", 32'({bus_we, bus_io, bus_addr}), 32'd0);

    load_loop(); run_prog(0, 500);
    load_loop(); run_prog(3, 500);
    load_io();   run_prog(0, 100);
    chk("io_mem_untouched", 32'(smem[8'h05]), 32'h93);
    load_io();   run_prog(-1, 100);

    // Reset while the first RD data transfer is in a wait state.
    load_loop();
    exp_q.delete();
    run_model(500, 3);
    wait_mode = 3;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    while (cyc < 200 && !(bus_req && !bus_we && bus_addr == 8'h20)) begin
      @(negedge clk);
      cyc++;
    end
    chk("found_xfer", 32'(cyc < 200), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_drop_req", 32'(bus_req), 32'd0);
    chk("rst_drop_pc", 32'(pc_dbg), 32'd0);
    load_loop(); run_prog(3, 500);

    for (int t = 0; t < 8; t++) begin
      load_random();
      run_prog((t < 3) ? t : -1, 60);
    end

    // Slave that never acknowledges.
    exp_q.delete();
    model_halted = 0;
    wait_mode = -2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
`ifdef SPM_BUS_TIMEOUT_EN
    repeat (15) @(posedge clk);
    #1;
    chk("to_not_yet", 32'(halted), 32'd0);
    @(posedge clk); #1;
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_err", 32'(bus_err), 32'd1);
    chk("to_req", 32'(bus_req), 32'd0);
`else
    repeat (101) @(posedge clk);
    #1;
    chk("noto_req", 32'(bus_req), 32'd1);
    chk("noto_halted", 32'(halted), 32'd0);
    chk("noto_err", 32'(bus_err), 32'd0);
`endif
    rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
